nt_subckt_bist_ctrl: RTL and testbench

- Stimulus/response end for one Nt_Node benchmark subcircuit (circuit under test, CUT).
- Generates LFSR pseudo-random input vectors that drive the CUT inputs, and resets the CUT before each run.
- Compacts the CUT's single output into a MISR signature and compares it against a golden value.
- Sits beside each CUT instance in the trojan-detection harness.

---
 rtl/nt_subckt_bist_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_nt_subckt_bist_ctrl.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nt_subckt_bist_ctrl.sv
// BIST stimulus/response controller for one Nt_Node benchmark subcircuit.
// Drives LFSR vectors into the CUT and folds its output into a MISR signature.
//
// Ports:
//   CLK         clock, all state updates on the rising edge
//   RST         synchronous active-high reset
//   start       one-cycle run request, honoured only in IDLE
//   abort       (only with BIST_ABORT_EN) cancels a run in INIT/RUN/DRAIN
//   golden_sig  expected signature, sampled in the DONE cycle
//   resp_in     CUT output
//   stim_out    CUT input vector, zero outside RUN
//   stim_valid  stim_out carries a live vector
//   cut_rst_n   active-low CUT reset, low during INIT
//   busy        high in INIT, RUN and DRAIN
//   done        one-cycle end-of-run pulse
//   pass        signature match, held until the next start
//   signature   current MISR value
//
// Optional feature macro: BIST_ABORT_EN adds the abort input.
module nt_subckt_bist_ctrl #(
    parameter int                NUM_IN        = 5,
    parameter int                LFSR_W        = 16,
    parameter logic [LFSR_W-1:0] SEED          = 16'hACE1,
    parameter logic [LFSR_W-1:0] POLY          = 16'h002D,
    parameter int                PATTERN_COUNT = 1000,
    parameter int                RESP_LAT      = 2,
    parameter int                INIT_CYC      = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
`ifdef BIST_ABORT_EN
    input  logic              abort,
`endif
    input  logic [LFSR_W-1:0] golden_sig,
    input  logic              resp_in,
    output logic [NUM_IN-1:0] stim_out,
    output logic              stim_valid,
    output logic              cut_rst_n,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [LFSR_W-1:0] signature
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    // One counter serves INIT, then RUN+DRAIN as a single
    // run-relative cycle index, so the capture test is one compare.
    localparam logic [16:0] INIT_LAST = 17'(INIT_CYC - 1);
    localparam logic [16:0] RUN_LAST  = 17'(PATTERN_COUNT - 1);
    localparam logic [16:0] LAT       = 17'(RESP_LAT);
    localparam logic [16:0] END_LAST  = 17'(PATTERN_COUNT + RESP_LAT - 1);

    state_t            state;
    logic [16:0]       cnt;
    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] misr;
    logic [LFSR_W-1:0] lfsr_nxt;
    logic [LFSR_W-1:0] misr_nxt;
    logic              capture;

    function automatic logic [LFSR_W-1:0] shift_fb(
        input logic [LFSR_W-1:0] v
    );
        return {v[LFSR_W-2:0], 1'b0} ^ (v[LFSR_W-1] ? POLY : '0);
    endfunction

    assign lfsr_nxt  = shift_fb(lfsr);
    assign misr_nxt  = shift_fb(misr) ^ {{(LFSR_W-1){1'b0}}, resp_in};
    assign signature = misr;

    // Response to vector k arrives RESP_LAT cycles later, so the
    // first RESP_LAT run-relative cycles carry nothing to capture.
    if (RESP_LAT == 0) begin : g_nolat
        assign capture = 1'b1;
    end else begin : g_lat
        assign capture = (cnt >= LAT);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_IDLE;
            cnt        <= '0;
            lfsr       <= SEED;
            misr       <= '0;
            stim_out   <= '0;
            stim_valid <= 1'b0;
            cut_rst_n  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end
`ifdef BIST_ABORT_EN
        else if (abort && (state == S_INIT ||
                           state == S_RUN  ||
                           state == S_DRAIN)) begin
            state      <= S_IDLE;
            cnt        <= '0;
            stim_out   <= '0;
            stim_valid <= 1'b0;
            cut_rst_n  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end
`endif
        else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_INIT;
                        cnt       <= '0;
                        lfsr      <= SEED;
                        misr      <= '0;
                        pass      <= 1'b0;
                        cut_rst_n <= 1'b0;
                        busy      <= 1'b1;
                    end
                end

                S_INIT: begin
                    if (cnt == INIT_LAST) begin
                        // Present pattern 0 on the first RUN cycle.
                        state      <= S_RUN;
                        cnt        <= '0;
                        cut_rst_n  <= 1'b1;
                        stim_out   <= lfsr[NUM_IN-1:0];
                        stim_valid <= 1'b1;
                        lfsr       <= lfsr_nxt;
                    end else begin
                        cnt <= cnt + 17'd1;
                    end
                end

                S_RUN: begin
                    if (capture) begin
                        misr <= misr_nxt;
                    end
                    cnt <= cnt + 17'd1;
                    if (cnt == RUN_LAST) begin
                        stim_out   <= '0;
                        stim_valid <= 1'b0;
                        if (RESP_LAT == 0) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= S_DRAIN;
                        end
                    end else begin
                        stim_out <= lfsr[NUM_IN-1:0];
                        lfsr     <= lfsr_nxt;
                    end
                end

                S_DRAIN: begin
                    if (capture) begin
                        misr <= misr_nxt;
                    end
                    cnt <= cnt + 17'd1;
                    if (cnt == END_LAST) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                    done  <= 1'b0;
                    pass  <= (misr == golden_sig);
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nt_subckt_bist_ctrl.sv
// Self-checking bench for nt_subckt_bist_ctrl.
// Three instances cover short, zero-latency and long randomized runs.
module tb_nt_subckt_bist_ctrl;

    localparam int PCS[3]  = '{4, 1, 40};
    localparam int RLS[3]  = '{0, 2, 3};
    localparam int INIS[3] = '{4, 4, 5};

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [2:0]  start = '0;
    logic [15:0] golden_sig = '0;
    logic        resp_in = 1'b0;
`ifdef BIST_ABORT_EN
    logic        abort = 1'b0;
`endif

    logic [4:0]  stim_w [3];
    logic [15:0] sig_w [3];
    logic [2:0]  valid_w, rstn_w, busy_w, done_w, pass_w;

    int vec_n = 0;
    int err_n = 0;

    int          busy_n, low_n, valid_n, done_n, idle_stim_n;
    logic        done_busy, pass_seen;
    logic [15:0] sig_at_done, exp_sig;
    logic [4:0]  vecs [64];
    logic        resp_hist [256];

    always #5 CLK = ~CLK;

    nt_subckt_bist_ctrl #(
        .PATTERN_COUNT(4), .RESP_LAT(0), .INIT_CYC(4)
    ) u_a (
        .CLK(CLK), .RST(RST), .start(start[0]),
`ifdef BIST_ABORT_EN
        .abort(abort),
`endif
        .golden_sig(golden_sig), .resp_in(resp_in),
        .stim_out(stim_w[0]), .stim_valid(valid_w[0]),
        .cut_rst_n(rstn_w[0]), .busy(busy_w[0]),
        .done(done_w[0]), .pass(pass_w[0]),
        .signature(sig_w[0])
    );

    nt_subckt_bist_ctrl #(
        .PATTERN_COUNT(1), .RESP_LAT(2), .INIT_CYC(4)
    ) u_b (
        .CLK(CLK), .RST(RST), .start(start[1]),
`ifdef BIST_ABORT_EN
        .abort(abort),
`endif
        .golden_sig(golden_sig), .resp_in(resp_in),
        .stim_out(stim_w[1]), .stim_valid(valid_w[1]),
        .cut_rst_n(rstn_w[1]), .busy(busy_w[1]),
        .done(done_w[1]), .pass(pass_w[1]),
        .signature(sig_w[1])
    );

    nt_subckt_bist_ctrl #(
        .PATTERN_COUNT(40), .RESP_LAT(3), .INIT_CYC(5)
    ) u_c (
        .CLK(CLK), .RST(RST), .start(start[2]),
`ifdef BIST_ABORT_EN
        .abort(abort),
`endif
        .golden_sig(golden_sig), .resp_in(resp_in),
        .stim_out(stim_w[2]), .stim_valid(valid_w[2]),
        .cut_rst_n(rstn_w[2]), .busy(busy_w[2]),
        .done(done_w[2]), .pass(pass_w[2]),
        .signature(sig_w[2])
    );

    // Reference model: Galois shift of the spec polynomial.
    function automatic logic [15:0] fb_shift(input logic [15:0] v);
        return (v << 1) ^ (v[15] ? 16'h002D : 16'h0000);
    endfunction

    function automatic logic [4:0] pattern(input int k);
        logic [15:0] p;
        p = 16'hACE1;
        for (int i = 0; i < k; i++) p = fb_shift(p);
        return p[4:0];
    endfunction

    // Fold the PATTERN_COUNT responses that arrive after the latency.
    function automatic logic [15:0] fold(input int rl, input int pc);
        logic [15:0] m;
        m = '0;
        for (int i = 0; i < pc; i++)
            m = fb_shift(m) ^ {15'b0, resp_hist[rl+i]};
        return m;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drives one run on instance s and records what it observed.
    // rmode: 0 resp=0, 1 resp=1, 2 random.
    // gmode: 0 golden=g, 1 golden=model, 2 golden=model^nonzero.
    task automatic run(input int s, input int rmode, input int gmode,
                       input logic [15:0] g, input int restart_at);
        int   rel;
        logic r;
        rel = -1;
        busy_n = 0; low_n = 0; valid_n = 0;
        done_n = 0; idle_stim_n = 0;
        done_busy = 1'b1;
        sig_at_done = '1;
        exp_sig = '0;
        golden_sig = g;
        start = '0;
        start[s] = 1'b1;
        tick();
        for (int c = 0; c < 60; c++) begin
            start = '0;
            if (c == restart_at) start[s] = 1'b1;
            if (busy_w[s]) busy_n++;
            if (!rstn_w[s]) low_n++;
            if (valid_w[s]) begin
                if (valid_n < 64) vecs[valid_n] = stim_w[s];
                valid_n++;
                if (rel < 0) rel = 0;
            end else if (stim_w[s] != 5'h00) begin
                idle_stim_n++;
            end
            if (done_w[s]) begin
                done_n++;
                done_busy = busy_w[s];
                sig_at_done = sig_w[s];
                exp_sig = fold(RLS[s], PCS[s]);
                if (gmode == 1) golden_sig = exp_sig;
                else if (gmode == 2)
                    golden_sig = exp_sig ^ 16'($urandom_range(1, 65535));
            end
            if (rmode == 0) r = 1'b0;
            else if (rmode == 1) r = 1'b1;
            else r = 1'($urandom % 2);
            resp_in = r;
            if (rel >= 0 && rel < 256) begin
                resp_hist[rel] = r;
                rel++;
            end
            tick();
        end
        start = '0;
        pass_seen = pass_w[s];
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        vec_n++;
        if ({stim_w[0], valid_w[0], rstn_w[0], busy_w[0],
             done_w[0], pass_w[0]} !== {5'h00, 5'b01000}) begin
            err_n++;
            $display("FAIL reset_ctl: got %h/%b%b%b%b%b want 00/01000",
                     stim_w[0], valid_w[0], rstn_w[0], busy_w[0],
                     done_w[0], pass_w[0]);
        end
        vec_n++;
        if (sig_w[2] !== 16'h0000) begin
            err_n++;
            $display("FAIL reset_sig: got %h want 0000", sig_w[2]);
        end
    endtask

    task automatic test_zero_resp();
        run(0, 0, 0, 16'h0000, -1);
        vec_n++;
        if (low_n !== 4) begin
            err_n++;
            $display("FAIL init_len: got %0d want 4", low_n);
        end
        vec_n++;
        if (busy_n !== 8) begin
            err_n++;
            $display("FAIL busy_len: got %0d want 8", busy_n);
        end
        vec_n++;
        if (valid_n !== 4 || idle_stim_n !== 0) begin
            err_n++;
            $display("FAIL valid_len: got %0d/%0d want 4/0",
                     valid_n, idle_stim_n);
        end
        vec_n++;
        if (vecs[0] !== 5'h01 || vecs[1] !== 5'h0F) begin
            err_n++;
            $display("FAIL first_vecs: got %h %h want 01 0F",
                     vecs[0], vecs[1]);
        end
        vec_n++;
        if (done_n !== 1 || done_busy !== 1'b0) begin
            err_n++;
            $display("FAIL done_pulse: got %0d busy=%b want 1 busy=0",
                     done_n, done_busy);
        end
        vec_n++;
        if (sig_at_done !== 16'h0000 || pass_seen !== 1'b1) begin
            err_n++;
            $display("FAIL zero_sig: got %h pass=%b want 0000 pass=1",
                     sig_at_done, pass_seen);
        end
    endtask

    task automatic test_ones_resp();
        run(0, 1, 0, 16'h000F, -1);
        vec_n++;
        if (sig_at_done !== 16'h000F || pass_seen !== 1'b1) begin
            err_n++;
            $display("FAIL ones_sig: got %h pass=%b want 000F pass=1",
                     sig_at_done, pass_seen);
        end
        vec_n++;
        if (sig_w[0] !== 16'h000F) begin
            err_n++;
            $display("FAIL sig_hold: got %h want 000F", sig_w[0]);
        end
        run(0, 1, 0, 16'h000E, -1);
        vec_n++;
        if (sig_at_done !== 16'h000F || pass_seen !== 1'b0) begin
            err_n++;
            $display("FAIL ones_bad_gold: got %h pass=%b want 000F pass=0",
                     sig_at_done, pass_seen);
        end
    endtask

    task automatic test_short_run();
        run(1, 1, 0, 16'h0001, -1);
        vec_n++;
        if (busy_n !== 7 || valid_n !== 1 || low_n !== 4) begin
            err_n++;
            $display("FAIL short_len: got busy=%0d valid=%0d low=%0d want 7 1 4",
                     busy_n, valid_n, low_n);
        end
        vec_n++;
        if (vecs[0] !== 5'h01 || done_n !== 1) begin
            err_n++;
            $display("FAIL short_vec: got %h done=%0d want 01 done=1",
                     vecs[0], done_n);
        end
        vec_n++;
        if (sig_at_done !== 16'h0001 || pass_seen !== 1'b1) begin
            err_n++;
            $display("FAIL short_sig: got %h pass=%b want 0001 pass=1",
                     sig_at_done, pass_seen);
        end
    endtask

    task automatic test_restart_ignored();
        // Cycle 5 is RUN cycle 1, cycle 8 is the DONE cycle.
        for (int i = 0; i < 2; i++) begin
            run(0, 1, 0, 16'h000F, (i == 0) ? 5 : 8);
            vec_n++;
            if (busy_n !== 8 || done_n !== 1 || valid_n !== 4) begin
                err_n++;
                $display("FAIL restart_%0d: got busy=%0d done=%0d valid=%0d want 8 1 4",
                         i, busy_n, done_n, valid_n);
            end
            vec_n++;
            if (sig_at_done !== 16'h000F || pass_seen !== 1'b1) begin
                err_n++;
                $display("FAIL restart_sig_%0d: got %h pass=%b want 000F pass=1",
                         i, sig_at_done, pass_seen);
            end
        end
    endtask

    task automatic test_rst_midrun();
        resp_in = 1'b1;
        start[0] = 1'b1;
        tick();
        start = '0;
        repeat (6) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        vec_n++;
        if ({stim_w[0], valid_w[0], rstn_w[0], busy_w[0],
             done_w[0], pass_w[0]} !== {5'h00, 5'b01000} ||
            sig_w[0] !== 16'h0000) begin
            err_n++;
            $display("FAIL rst_mid: got %h/%b%b%b%b%b sig=%h want 00/01000 sig=0000",
                     stim_w[0], valid_w[0], rstn_w[0], busy_w[0],
                     done_w[0], pass_w[0], sig_w[0]);
        end
        run(0, 0, 0, 16'h0000, -1);
        vec_n++;
        if (vecs[0] !== 5'h01 || vecs[1] !== 5'h0F ||
            done_n !== 1 || pass_seen !== 1'b1) begin
            err_n++;
            $display("FAIL rst_rerun: got %h %h done=%0d pass=%b want 01 0F 1 1",
                     vecs[0], vecs[1], done_n, pass_seen);
        end
    endtask

    task automatic test_random();
        int bad;
        for (int it = 0; it < 4; it++) begin
            run(2, 2, (it % 2 == 0) ? 1 : 2, 16'h0000, -1);
            vec_n++;
            if (busy_n !== 48 || low_n !== 5 || valid_n !== 40 ||
                idle_stim_n !== 0 || done_n !== 1) begin
                err_n++;
                $display("FAIL rand_len_%0d: got %0d %0d %0d %0d %0d want 48 5 40 0 1",
                         it, busy_n, low_n, valid_n, idle_stim_n, done_n);
            end
            bad = 0;
            for (int k = 0; k < 40; k++)
                if (vecs[k] !== pattern(k)) bad++;
            vec_n++;
            if (bad !== 0) begin
                err_n++;
                $display("FAIL rand_vecs_%0d: got %0d wrong want 0", it, bad);
            end
            vec_n++;
            if (sig_at_done !== exp_sig) begin
                err_n++;
                $display("FAIL rand_sig_%0d: got %h want %h",
                         it, sig_at_done, exp_sig);
            end
            vec_n++;
            if (pass_seen !== (it % 2 == 0)) begin
                err_n++;
                $display("FAIL rand_pass_%0d: got %b want %b",
                         it, pass_seen, (it % 2 == 0));
            end
        end
    endtask

`ifdef BIST_ABORT_EN
    task automatic test_abort();
        int dn;
        run(0, 0, 0, 16'h0000, -1);
        resp_in = 1'b1;
        start[0] = 1'b1;
        tick();
        start = '0;
        repeat (6) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        vec_n++;
        if ({valid_w[0], rstn_w[0], busy_w[0], done_w[0], pass_w[0]}
            !== 5'b01000 || stim_w[0] !== 5'h00) begin
            err_n++;
            $display("FAIL abort_state: got %b%b%b%b%b stim=%h want 01000 stim=00",
                     valid_w[0], rstn_w[0], busy_w[0], done_w[0],
                     pass_w[0], stim_w[0]);
        end
        dn = 0;
        for (int c = 0; c < 20; c++) begin
            if (done_w[0] || busy_w[0]) dn++;
            tick();
        end
        vec_n++;
        if (dn !== 0) begin
            err_n++;
            $display("FAIL abort_nodone: got %0d active cycles want 0", dn);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_zero_resp();
        test_ones_resp();
        test_short_run();
        test_restart_ignored();
        test_rst_midrun();
        test_random();
`ifdef BIST_ABORT_EN
        test_abort();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
        $finish;
    end

endmodule
